// File: rtl/dcache_arb_pkg.sv
// Shared definitions for the two-requester data-cache port arbiter.
package dcache_arb_pkg;

    localparam int unsigned ID_W     = 4;
    localparam int unsigned NUM_TAGS = 16;

    localparam logic REQ_R0 = 1'b0;
    localparam logic REQ_R1 = 1'b1;

    // One outstanding memory tag: who issued it and under which local ID.
    typedef struct packed {
        logic            owner;
        logic [ID_W-1:0] id;
        logic            alloc;
    } tag_entry_t;

endpackage

// File: rtl/tag_alloc_table.sv
// Memory-tag allocator: free bitmap, lowest-free encoder, per-tag owner/id storage.
module tag_alloc_table #(
    parameter int unsigned ID_W     = 4,
    parameter int unsigned NUM_TAGS = 16
) (
    input  logic            clk,
    input  logic            rst,
    // allocation side
    input  logic            alloc_en,
    input  logic            alloc_owner,
    input  logic [ID_W-1:0] alloc_id,
    output logic            alloc_avail,
    output logic [ID_W-1:0] alloc_tag,
    // lookup / free side
    input  logic [ID_W-1:0] lookup_tag,
    output logic            lookup_alloc,
    output logic            lookup_owner,
    output logic [ID_W-1:0] lookup_id,
    input  logic            free_en,
    output logic [ID_W:0]   outstanding
);
    import dcache_arb_pkg::*;

    logic [NUM_TAGS-1:0] free_q, free_d;
    tag_entry_t          entry_q [NUM_TAGS];
    tag_entry_t          entry_d [NUM_TAGS];
    logic [ID_W:0]       count_q, count_d;

    // Lowest-numbered free tag, taken from the registered bitmap only.
    always_comb begin
        alloc_avail = |free_q;
        alloc_tag   = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                alloc_tag = ID_W'(i);
            end
        end
    end

    // Registered table read for response routing.
    always_comb begin
        lookup_alloc = entry_q[lookup_tag].alloc;
        lookup_owner = entry_q[lookup_tag].owner;
        lookup_id    = entry_q[lookup_tag].id;
        outstanding  = count_q;
    end

    // Free and allocate never target the same tag: one is allocated, the other free.
    always_comb begin
        free_d  = free_q;
        entry_d = entry_q;
        count_d = count_q + (ID_W+1)'(alloc_en) - (ID_W+1)'(free_en);
        if (free_en) begin
            free_d[lookup_tag]        = 1'b1;
            entry_d[lookup_tag].alloc = 1'b0;
        end
        if (alloc_en) begin
            free_d[alloc_tag]        = 1'b0;
            entry_d[alloc_tag].owner = alloc_owner;
            entry_d[alloc_tag].id    = alloc_id;
            entry_d[alloc_tag].alloc = 1'b1;
        end
    end

    // Table state; reset marks every tag free.
    always_ff @(posedge clk) begin
        if (rst) begin
            free_q  <= '1;
            count_q <= '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            free_q  <= free_d;
            count_q <= count_d;
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Round-robin sharing of one tagged data-memory port between two requesters.
module dcache_port_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned NUM_TAGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    input  logic [DATA_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_data,
    input  logic              r0_rw,
    input  logic [ID_W-1:0]   r0_id,
    output logic              r0_grant,
    output logic              r0_resp_valid,
    output logic [DATA_W-1:0] r0_resp_data,
    output logic [ID_W-1:0]   r0_resp_id,
    input  logic              r1_valid,
    input  logic [DATA_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_data,
    input  logic              r1_rw,
    input  logic [ID_W-1:0]   r1_id,
    output logic              r1_grant,
    output logic              r1_resp_valid,
    output logic [DATA_W-1:0] r1_resp_data,
    output logic [ID_W-1:0]   r1_resp_id,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_rw,
    output logic [ID_W-1:0]   mem_id,
    output logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic [ID_W-1:0]   mem_id_in,
    input  logic              mem_ready_in,
    input  logic              mem_stall_in,
    output logic [ID_W:0]     outstanding,
    output logic              err_unexpected
);
    import dcache_arb_pkg::*;

    logic              prio_q, prio_d;
    logic              grant0, grant1, any_grant;
    logic              alloc_avail, alloc_owner;
    logic [ID_W-1:0]   alloc_id, alloc_tag;
    logic              lk_alloc, lk_owner, hit, free_en;
    logic [ID_W-1:0]   lk_id;

    logic              mem_valid_q, mem_valid_d, mem_rw_q, mem_rw_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
    logic [ID_W-1:0]   mem_id_q, mem_id_d;
    logic              r0_rv_q, r0_rv_d, r1_rv_q, r1_rv_d, err_q, err_d;
    logic [DATA_W-1:0] r0_rd_q, r0_rd_d, r1_rd_q, r1_rd_d;
    logic [ID_W-1:0]   r0_ri_q, r0_ri_d, r1_ri_q, r1_ri_d;

    // Arbitration: prio_q names the requester that wins a tie.
    always_comb begin
        logic eligible;
        eligible    = !rst && !mem_stall_in && alloc_avail;
        grant0      = eligible && r0_valid && (!r1_valid || prio_q == REQ_R0);
        grant1      = eligible && r1_valid && (!r0_valid || prio_q == REQ_R1);
        any_grant   = grant0 || grant1;
        alloc_owner = grant1 ? REQ_R1 : REQ_R0;
        alloc_id    = grant1 ? r1_id : r0_id;
        prio_d      = prio_q;
        if (grant0) begin
            prio_d = REQ_R1;
        end else if (grant1) begin
            prio_d = REQ_R0;
        end
    end

    // Issue register: payload holds when nothing is granted.
    always_comb begin
        mem_valid_d = any_grant;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_rw_d    = mem_rw_q;
        mem_id_d    = mem_id_q;
        if (grant0) begin
            mem_addr_d = r0_addr;
            mem_data_d = r0_data;
            mem_rw_d   = r0_rw;
            mem_id_d   = alloc_tag;
        end else if (grant1) begin
            mem_addr_d = r1_addr;
            mem_data_d = r1_data;
            mem_rw_d   = r1_rw;
            mem_id_d   = alloc_tag;
        end
    end

    // Response routing: a hit pulses the owner's resp_valid; a miss is dropped and flagged.
    always_comb begin
        hit     = mem_ready_in && lk_alloc;
        free_en = hit && !rst;
        r0_rv_d = hit && (lk_owner == REQ_R0);
        r1_rv_d = hit && (lk_owner == REQ_R1);
        r0_rd_d = r0_rd_q;
        r0_ri_d = r0_ri_q;
        r1_rd_d = r1_rd_q;
        r1_ri_d = r1_ri_q;
        if (r0_rv_d) begin
            r0_rd_d = mem_data_in;
            r0_ri_d = lk_id;
        end
        if (r1_rv_d) begin
            r1_rd_d = mem_data_in;
            r1_ri_d = lk_id;
        end
        err_d = err_q || (mem_ready_in && !lk_alloc);
    end

    tag_alloc_table #(
        .ID_W     (ID_W),
        .NUM_TAGS (NUM_TAGS)
    ) u_tags (
        .clk          (clk),
        .rst          (rst),
        .alloc_en     (any_grant),
        .alloc_owner  (alloc_owner),
        .alloc_id     (alloc_id),
        .alloc_avail  (alloc_avail),
        .alloc_tag    (alloc_tag),
        .lookup_tag   (mem_id_in),
        .lookup_alloc (lk_alloc),
        .lookup_owner (lk_owner),
        .lookup_id    (lk_id),
        .free_en      (free_en),
        .outstanding  (outstanding)
    );

    // Registered outputs and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q      <= REQ_R0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_rw_q    <= 1'b0;
            mem_id_q    <= '0;
            r0_rv_q     <= 1'b0;
            r0_rd_q     <= '0;
            r0_ri_q     <= '0;
            r1_rv_q     <= 1'b0;
            r1_rd_q     <= '0;
            r1_ri_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_rw_q    <= mem_rw_d;
            mem_id_q    <= mem_id_d;
            r0_rv_q     <= r0_rv_d;
            r0_rd_q     <= r0_rd_d;
            r0_ri_q     <= r0_ri_d;
            r1_rv_q     <= r1_rv_d;
            r1_rd_q     <= r1_rd_d;
            r1_ri_q     <= r1_ri_d;
            err_q       <= err_d;
        end
    end

    assign r0_grant       = grant0;
    assign r1_grant       = grant1;
    assign mem_valid      = mem_valid_q;
    assign mem_addr       = mem_addr_q;
    assign mem_data       = mem_data_q;
    assign mem_rw         = mem_rw_q;
    assign mem_id         = mem_id_q;
    assign r0_resp_valid  = r0_rv_q;
    assign r0_resp_data   = r0_rd_q;
    assign r0_resp_id     = r0_ri_q;
    assign r1_resp_valid  = r1_rv_q;
    assign r1_resp_data   = r1_rd_q;
    assign r1_resp_id     = r1_ri_q;
    assign err_unexpected = err_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter: a behavioural tag/queue model predicts
// grants, issues, responses and counters; a negedge monitor compares them.
module tb_dcache_port_arbiter;

    localparam int NT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r0_rw, r1_valid, r1_rw;
    logic [31:0] r0_addr, r0_data, r1_addr, r1_data;
    logic [3:0]  r0_id, r1_id;
    logic        r0_grant, r1_grant;
    logic        r0_resp_valid, r1_resp_valid;
    logic [31:0] r0_resp_data, r1_resp_data;
    logic [3:0]  r0_resp_id, r1_resp_id;
    logic [31:0] mem_addr, mem_data, mem_data_in;
    logic        mem_rw, mem_valid, mem_ready_in, mem_stall_in;
    logic [3:0]  mem_id, mem_id_in;
    logic [4:0]  outstanding;
    logic        err_unexpected;

    dcache_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .r0_valid       (r0_valid),
        .r0_addr        (r0_addr),
        .r0_data        (r0_data),
        .r0_rw          (r0_rw),
        .r0_id          (r0_id),
        .r0_grant       (r0_grant),
        .r0_resp_valid  (r0_resp_valid),
        .r0_resp_data   (r0_resp_data),
        .r0_resp_id     (r0_resp_id),
        .r1_valid       (r1_valid),
        .r1_addr        (r1_addr),
        .r1_data        (r1_data),
        .r1_rw          (r1_rw),
        .r1_id          (r1_id),
        .r1_grant       (r1_grant),
        .r1_resp_valid  (r1_resp_valid),
        .r1_resp_data   (r1_resp_data),
        .r1_resp_id     (r1_resp_id),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_rw         (mem_rw),
        .mem_id         (mem_id),
        .mem_valid      (mem_valid),
        .mem_data_in    (mem_data_in),
        .mem_id_in      (mem_id_in),
        .mem_ready_in   (mem_ready_in),
        .mem_stall_in   (mem_stall_in),
        .outstanding    (outstanding),
        .err_unexpected (err_unexpected)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic g0; logic g1; } exp_grant_t;
    typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; logic rw; logic [3:0] tag; } exp_issue_t;
    typedef struct { int cyc; logic [31:0] data; logic [3:0] id; } exp_resp_t;
    typedef struct { int cyc; int cnt; logic err; logic was_rst; } exp_state_t;

    exp_grant_t gq[$];
    exp_issue_t iq[$];
    exp_resp_t  rq0[$];
    exp_resp_t  rq1[$];
    exp_state_t sq[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: which tags are in use and by whom, plus fairness history.
    bit       m_alloc [NT];
    bit       m_owner [NT];
    bit [3:0] m_id    [NT];
    int       m_cnt;
    bit       m_err;
    bit       m_last;   // requester granted most recently

    logic [31:0] last_addr;
    logic [3:0]  last_tag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) m_alloc[i] = 1'b0;
        m_cnt  = 0;
        m_err  = 1'b0;
        m_last = 1'b1;  // so r0 wins the first tie
    endtask

    // Predict this cycle from the driven inputs, then advance one clock.
    task automatic tick();
        exp_grant_t g;
        exp_issue_t is;
        exp_resp_t  rs;
        exp_state_t st;
        int         tag;
        bit         e0, e1;
        g.cyc = cyc; st.cyc = cyc;
        e0 = 1'b0; e1 = 1'b0;
        if (rst) begin
            model_reset();
            st.was_rst = 1'b1;
        end else begin
            st.was_rst = 1'b0;
            if (!mem_stall_in && m_cnt < NT) begin
                if (r0_valid && r1_valid) begin
                    e0 = (m_last == 1'b1);
                    e1 = !e0;
                end else begin
                    e0 = r0_valid;
                    e1 = r1_valid;
                end
            end
            tag = 0;
            while (tag < NT && m_alloc[tag]) tag++;
            if (mem_ready_in) begin
                if (m_alloc[mem_id_in]) begin
                    rs.cyc  = cyc;
                    rs.data = mem_data_in;
                    rs.id   = m_id[mem_id_in];
                    if (m_owner[mem_id_in]) rq1.push_back(rs);
                    else rq0.push_back(rs);
                    m_alloc[mem_id_in] = 1'b0;
                    m_cnt--;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (e0 || e1) begin
                is.cyc  = cyc;
                is.addr = e1 ? r1_addr : r0_addr;
                is.data = e1 ? r1_data : r0_data;
                is.rw   = e1 ? r1_rw : r0_rw;
                is.tag  = 4'(tag);
                iq.push_back(is);
                m_alloc[tag] = 1'b1;
                m_owner[tag] = e1;
                m_id[tag]    = e1 ? r1_id : r0_id;
                m_cnt++;
                m_last = e1;
            end
        end
        g.g0 = e0; g.g1 = e1;
        gq.push_back(g);
        st.cnt = m_cnt; st.err = m_err;
        sq.push_back(st);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        r0_valid = 1'b0; r1_valid = 1'b0;
        mem_ready_in = 1'b0; mem_stall_in = 1'b0;
    endtask

    task automatic respond(input int tag, input logic [31:0] data);
        mem_ready_in = 1'b1;
        mem_id_in    = 4'(tag);
        mem_data_in  = data;
        tick();
        mem_ready_in = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < NT; i++) begin
            if (m_alloc[i]) respond(i, $urandom);
        end
    endtask

    task automatic rand_req(input int which, input logic [3:0] id);
        if (which == 0) begin
            r0_valid = 1'b1; r0_addr = $urandom; r0_data = $urandom;
            r0_rw = 1'($urandom_range(0, 1)); r0_id = id;
        end else begin
            r1_valid = 1'b1; r1_addr = $urandom; r1_data = $urandom;
            r1_rw = 1'($urandom_range(0, 1)); r1_id = id;
        end
    endtask

    task automatic apply_reset(input int n);
        idle();
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    // Monitor: grants in the current cycle, registered outputs for the previous edge.
    initial begin
        forever begin
            @(negedge clk);
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                exp_grant_t g;
                g = gq.pop_front();
                check("r0_grant", 32'(r0_grant), 32'(g.g0));
                check("r1_grant", 32'(r1_grant), 32'(g.g1));
            end
            if (cyc >= 1) begin
                if (sq.size() > 0 && sq[0].cyc == cyc - 1) begin
                    exp_state_t s;
                    s = sq.pop_front();
                    check("outstanding", 32'(outstanding), 32'(s.cnt));
                    check("err_unexpected", 32'(err_unexpected), 32'(s.err));
                    if (s.was_rst) begin
                        last_addr = '0;
                        last_tag  = '0;
                    end
                end
                if (iq.size() > 0 && iq[0].cyc == cyc - 1) begin
                    exp_issue_t e;
                    e = iq.pop_front();
                    check("mem_valid", 32'(mem_valid), 32'd1);
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_data", mem_data, e.data);
                    check("mem_rw", 32'(mem_rw), 32'(e.rw));
                    check("mem_id", 32'(mem_id), 32'(e.tag));
                    last_addr = e.addr;
                    last_tag  = e.tag;
                end else begin
                    check("mem_valid_idle", 32'(mem_valid), 32'd0);
                    check("mem_addr_hold", mem_addr, last_addr);
                    check("mem_id_hold", 32'(mem_id), 32'(last_tag));
                end
                if (rq0.size() > 0 && rq0[0].cyc == cyc - 1) begin
                    exp_resp_t r;
                    r = rq0.pop_front();
                    check("r0_resp_valid", 32'(r0_resp_valid), 32'd1);
                    check("r0_resp_data", r0_resp_data, r.data);
                    check("r0_resp_id", 32'(r0_resp_id), 32'(r.id));
                end else begin
                    check("r0_resp_valid_idle", 32'(r0_resp_valid), 32'd0);
                end
                if (rq1.size() > 0 && rq1[0].cyc == cyc - 1) begin
                    exp_resp_t r;
                    r = rq1.pop_front();
                    check("r1_resp_valid", 32'(r1_resp_valid), 32'd1);
                    check("r1_resp_data", r1_resp_data, r.data);
                    check("r1_resp_id", 32'(r1_resp_id), 32'(r.id));
                end else begin
                    check("r1_resp_valid_idle", 32'(r1_resp_valid), 32'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        last_addr = '0; last_tag = '0;
        r0_addr = '0; r0_data = '0; r0_rw = 1'b0; r0_id = '0;
        r1_addr = '0; r1_data = '0; r1_rw = 1'b0; r1_id = '0;
        mem_id_in = '0; mem_data_in = '0;
        idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset(2);

        // Single load: tag 0, response routed back with the original id.
        r0_valid = 1'b1; r0_addr = 32'h10; r0_data = '0; r0_rw = 1'b0; r0_id = 4'd5;
        tick();
        idle(); tick();
        respond(0, 32'hAB);
        tick();

        // Contention from a fresh reset: alternation r0, r1, r0, r1 on tags 0..3.
        apply_reset(1);
        for (int i = 0; i < 4; i++) begin
            rand_req(0, 4'(i + 8));
            rand_req(1, 4'(i + 2));
            tick();
        end
        idle(); tick();
        for (int t = 0; t < 4; t++) respond(t, $urandom);

        // Full: 17 r1 requests, then a free on tag 7 which is reused a cycle later.
        for (int i = 0; i < 17; i++) begin
            rand_req(1, 4'(i));
            tick();
        end
        mem_ready_in = 1'b1; mem_id_in = 4'd7; mem_data_in = 32'h7777;
        tick();
        mem_ready_in = 1'b0;
        tick();
        idle();
        drain();

        // Simultaneous free of tag 0 with a new request while tags 0-2 are busy.
        for (int i = 0; i < 3; i++) begin
            rand_req(0, 4'(i));
            tick();
        end
        rand_req(0, 4'd12);
        mem_ready_in = 1'b1; mem_id_in = 4'd0; mem_data_in = 32'h5A5A;
        tick();
        idle();
        drain();

        // Stall holds off grants for three cycles.
        mem_stall_in = 1'b1;
        rand_req(0, 4'd3);
        for (int i = 0; i < 3; i++) tick();
        mem_stall_in = 1'b0;
        tick();
        idle();
        drain();

        // Unexpected tag, then reset with requests in flight.
        respond(9, 32'hDEAD);
        rand_req(0, 4'd1); tick();
        rand_req(1, 4'd2); tick();
        idle(); tick();
        apply_reset(1);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_data", mem_data, 32'd0);
        check("rst_mem_rw", 32'(mem_rw), 32'd0);
        check("rst_mem_id", 32'(mem_id), 32'd0);
        check("rst_r0_resp", {r0_resp_data[27:0], r0_resp_id}, 32'd0);
        check("rst_r1_resp", {r1_resp_data[27:0], r1_resp_id}, 32'd0);
        check("rst_resp_valid", 32'({r0_resp_valid, r1_resp_valid}), 32'd0);
        check("rst_outstanding", 32'(outstanding), 32'd0);
        check("rst_err", 32'(err_unexpected), 32'd0);

        // Randomised traffic including fills, stalls, stray tags and occasional resets.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            r0_valid = 1'b0; r1_valid = 1'b0;
            if ($urandom_range(0, 1) == 1) rand_req(0, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) rand_req(1, 4'($urandom_range(0, 15)));
            mem_stall_in = ($urandom_range(0, 7) == 0);
            mem_ready_in = 1'($urandom_range(0, 1));
            mem_data_in  = $urandom;
            mem_id_in    = 4'($urandom_range(0, 15));
            if (mem_ready_in && m_cnt > 0 && $urandom_range(0, 15) != 0) begin
                int k;
                bit found;
                k = $urandom_range(0, 15);
                found = 1'b0;
                for (int j = 0; j < NT; j++) begin
                    if (!found && m_alloc[(k + j) % NT]) begin
                        mem_id_in = 4'((k + j) % NT);
                        found = 1'b1;
                    end
                end
            end
            tick();
        end
        rst = 1'b0;
        idle();
        drain();
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        #1;
        check("grant_queue_drained", 32'(gq.size()), 32'd0);
        check("issue_queue_drained", 32'(iq.size()), 32'd0);
        check("r0_resp_queue_drained", 32'(rq0.size()), 32'd0);
        check("r1_resp_queue_drained", 32'(rq1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
Shares the single data-memory request port (DCache4KBNew-style: addr/data/rw/id/valid in; data/id/ready out; stall out) between two requesters. Requester 0 is the core load/store queue; requester 1 is a secondary agent such as a refill or debug port.
- Arbitrates round-robin between the two requesters.
- Remaps each requester's 4-bit ID onto a private memory tag.
- Tracks outstanding requests in a tag table.
- Routes each memory response back to the requester that issued it, with that requester's original ID.

Parameters:
DATA_W, 32, address and data width
ID_W, 4, requester-ID and memory-tag width
NUM_TAGS, 16, memory tags available (must equal 2**ID_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
r0_valid  in  1  requester 0 request present
r0_addr  in  DATA_W  request address
r0_data  in  DATA_W  store data
r0_rw  in  1  1=store, 0=load
r0_id  in  ID_W  requester-local ID
r0_grant  out  1  request accepted this cycle (combinational)
r0_resp_valid  out  1  response for requester 0
r0_resp_data  out  DATA_W  response data
r0_resp_id  out  ID_W  original r0_id of the completed request
r1_*  —  same set of signals as r0_*, for requester 1
mem_addr  out  DATA_W  to memory addr_in
mem_data  out  DATA_W  to memory data_in
mem_rw  out  1  to memory rw_in
mem_id  out  ID_W  memory tag
mem_valid  out  1  to memory valid_in
mem_data_in  in  DATA_W  from memory data_out
mem_id_in  in  ID_W  from memory id_out
mem_ready_in  in  1  from memory ready_out
mem_stall_in  in  1  from memory stall_out
outstanding  out  ID_W+1  allocated tag count, 0..16
err_unexpected  out  1  sticky: response arrived on an unallocated tag

Behaviour:
Clocking and reset:
- Single clock clk; reset rst is synchronous and active-high.
- While rst is high at a clk edge, all of the following clear: the tag table, the free bitmap (all tags free), the round-robin pointer (favours r0), and outstanding.
- All registered outputs reset to 0: mem_*, r*_resp_*, err_unexpected.
- Grants are 0 during reset.

Eligibility:
- A grant may issue only when mem_stall_in=0, at least one tag is free in the registered bitmap, and rst=0.

Arbitration:
- Exactly one grant per cycle, at most.
- Only one requester valid: that requester is granted.
- Both valid: the requester not granted most recently wins.
- The pointer updates only on a grant.

Tag allocation:
- The granted request takes the lowest-numbered free tag.
- Its table entry stores {requester, original id}.

Issue:
- A request granted in cycle N appears on mem_* at cycle N+1 with mem_valid=1.
- mem_valid=0 in any cycle following a no-grant cycle.
- mem_addr/mem_data/mem_rw/mem_id hold their last values when mem_valid=0.

Response handling:
- When mem_ready_in=1 at edge N, the arbiter looks up mem_id_in in the table.
- If the tag is allocated: rX_resp_valid=1 at N+1 on the owning requester, with rX_resp_data=mem_data_in and rX_resp_id set to the stored id. The tag is freed at the same edge.
- rX_resp_valid is a one-cycle pulse. The non-owning requester's resp_valid stays 0.
- Stores also produce a response, carrying the store data echoed by memory.

Simultaneous free and allocate:
- A tag freed at edge N is not allocatable until cycle N+1, because allocation reads the registered bitmap.
- outstanding updates as +grant −free in the same edge, so it is unchanged when both happen together.

Full condition:
- With outstanding=16, no grants are issued. This resumes the cycle after any free.

Stall:
- mem_stall_in suppresses grants combinationally.
- A request already registered on mem_* is not withdrawn.

Unexpected response:
- A response whose tag is unallocated is dropped: no resp_valid, no state change.
- err_unexpected is set and stays set until reset.

Reset mid-operation:
- All in-flight tags are discarded.
- Memory must be reset at the same time. Any stale response after reset is treated as unexpected.

Width rules:
- outstanding is 5 bits and saturates by construction at 16.
- All pointer and tag arithmetic is modulo 16.

Decomposition:
- Shared package dcache_arb_pkg: REQ_R0/REQ_R1 constants, ID_W, NUM_TAGS, and a tag-entry typedef {owner bit, id[ID_W-1:0], alloc bit}.
- One sub-module, tag_alloc_table: free bitmap, lowest-free priority encoder, entry storage, alloc/free ports.
- Arbitration, issue registers and response routing stay at top level.

Test Plan:
- Single load: r0_valid, addr 0x10, id 5, after reset → r0_grant at cycle 1; mem_valid with mem_id 0 at cycle 2; mem_ready_in with id 0 and data 0xAB → r0_resp_valid, resp_data 0xAB, resp_id 5 one cycle later; outstanding back to 0.
- Contention: r0 and r1 valid for 4 cycles → grants alternate r0, r1, r0, r1; tags 0, 1, 2, 3; responses route to r0 for tags 0 and 2 and to r1 for tags 1 and 3, each with its original id.
- Full: 16 back-to-back r1 requests with no responses → outstanding=16 and r1_grant=0 on request 17; respond on tag 7 → grant resumes the following cycle and reuses tag 7.
- Simultaneous: in the same cycle a response frees tag 0 and r0 requests while tags 0-2 are allocated → new request gets tag 3 and outstanding is unchanged.
- Stall: mem_stall_in=1 for 3 cycles with r0_valid → no grants, mem_valid=0; on release, grant next cycle.
- Error and reset: mem_ready_in with unallocated tag 9 → no resp_valid, err_unexpected=1; assert rst with 2 tags outstanding → outstanding=0, err_unexpected=0, all outputs 0.
